// File: rtl/note_classifier.sv
// note_classifier: waits for freq_in to stay unchanged for STABLE_CYCLES
// cycles, normalizes it into the 254..508 Hz band, finds the nearest
// equal-tempered note and reports note index, octave and the residual error.
module note_classifier #(
   parameter int STABLE_CYCLES = 1024
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] freq_in,
   output logic [3:0]  note_idx,
   output logic [3:0]  octave,
   output logic [9:0]  freq_err,
   output logic        out_of_range,
   output logic        note_valid,
   output logic        busy
);

   localparam int CNT_W = $clog2(STABLE_CYCLES + 1);

   typedef enum logic [1:0] {IDLE, NORM, SEARCH, DONE} state_t;

   state_t            state;
   logic [CNT_W-1:0]  stab_cnt;
   logic [15:0]       freq_prev;
   logic [15:0]       last_val;
   logic              have_result;
   logic [15:0]       work;
   logic [3:0]        oct_acc;
   logic [3:0]        srch_idx;
   logic [3:0]        best_idx;
   logic signed [9:0] best_err;
   logic [8:0]        best_abs;
   logic              oor_flag;
   logic signed [9:0] cur_err;
   logic [8:0]        cur_abs;
   logic              trigger;

   // Reference frequencies of octave 4, C..B
   function automatic logic [8:0] table_hz(input logic [3:0] idx);
      case (idx)
         4'd0:    table_hz = 9'd262;
         4'd1:    table_hz = 9'd277;
         4'd2:    table_hz = 9'd294;
         4'd3:    table_hz = 9'd311;
         4'd4:    table_hz = 9'd330;
         4'd5:    table_hz = 9'd349;
         4'd6:    table_hz = 9'd370;
         4'd7:    table_hz = 9'd392;
         4'd8:    table_hz = 9'd415;
         4'd9:    table_hz = 9'd440;
         4'd10:   table_hz = 9'd466;
         default: table_hz = 9'd494;
      endcase
   endfunction

   // Magnitude of a normalized-band error; band limits keep it below 256
   function automatic logic [8:0] abs_err(input logic signed [9:0] e);
      logic [9:0] m;
      m = e[9] ? 10'(-e) : 10'(e);
      abs_err = m[8:0];
   endfunction

   // Work is confined to 254..508 while searching, so 9 bits are exact
   assign cur_err = signed'({1'b0, work[8:0]}) - signed'({1'b0, table_hz(srch_idx)});
   assign cur_abs = abs_err(cur_err);
   assign trigger = (state == IDLE) && (stab_cnt == CNT_W'(STABLE_CYCLES)) &&
                    (!have_result || (freq_in != last_val));
   assign busy    = (state != IDLE);

   // Previous-cycle input, used only for change detection
   always_ff @(posedge clk) begin
      freq_prev <= freq_in;
   end

   // Stability counter: restarts on any input change, saturates at STABLE_CYCLES
   always_ff @(posedge clk) begin
      if (reset)
         stab_cnt <= '0;
      else if (freq_in != freq_prev)
         stab_cnt <= '0;
      else if (stab_cnt != CNT_W'(STABLE_CYCLES))
         stab_cnt <= stab_cnt + CNT_W'(1);
   end

   // Classification FSM: capture, octave normalization, table search, publish
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         have_result  <= 1'b0;
         note_idx     <= '0;
         octave       <= '0;
         freq_err     <= '0;
         out_of_range <= 1'b0;
         note_valid   <= 1'b0;
      end else begin
         note_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (trigger) begin
                  work        <= freq_in;
                  oct_acc     <= 4'd4;
                  last_val    <= freq_in;
                  have_result <= 1'b1;
                  if ((freq_in < 16'd16) || (freq_in > 16'd8000)) begin
                     oor_flag <= 1'b1;
                     state    <= DONE;
                  end else begin
                     oor_flag <= 1'b0;
                     state    <= NORM;
                  end
               end
            end
            NORM: begin
               if (work < 16'd254) begin
                  work    <= work << 1;
                  oct_acc <= oct_acc - 4'd1;
               end else if (work >= 16'd509) begin
                  work    <= work >> 1;
                  oct_acc <= oct_acc + 4'd1;
               end else begin
                  srch_idx <= 4'd0;
                  state    <= SEARCH;
               end
            end
            SEARCH: begin
               // Strict less-than keeps the lower index on ties
               if ((srch_idx == 4'd0) || (cur_abs < best_abs)) begin
                  best_idx <= srch_idx;
                  best_err <= cur_err;
                  best_abs <= cur_abs;
               end
               if (srch_idx == 4'd11)
                  state <= DONE;
               else
                  srch_idx <= srch_idx + 4'd1;
            end
            DONE: begin
               note_valid <= 1'b1;
               if (oor_flag) begin
                  note_idx     <= '0;
                  octave       <= '0;
                  freq_err     <= '0;
                  out_of_range <= 1'b1;
               end else begin
                  note_idx     <= best_idx;
                  octave       <= oct_acc;
                  freq_err     <= best_err;
                  out_of_range <= 1'b0;
               end
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/note_classifier.md
NOTE_CLASSIFIER -- requirements
Module: note_classifier

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 1024: consecutive unchanged-input cycles required before classification.
REQ-002 SHALL have port clk  input  1  system clock (50 MHz); all logic on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port freq_in  input  16  measured frequency in Hz from the frequency measurement stage; no strobe, value may change any cycle.
REQ-005 SHALL have port note_idx  output  4  nearest note, 0=C .. 11=B.
REQ-006 SHALL have port octave  output  4  scientific octave number, 0..8.
REQ-007 SHALL have port freq_err  output  10  signed, two's complement: normalized frequency minus table frequency, Hz.
REQ-008 SHALL have port out_of_range  output  1  last classified input was outside 16..8000 Hz.
REQ-009 SHALL have port note_valid  output  1  one-cycle pulse when outputs update.
REQ-010 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-011 SHALL keep a stability counter: reset to 0 when freq_in differs from its previous-cycle value; otherwise increment; saturate at STABLE_CYCLES.
REQ-012 SHALL trigger when state=IDLE, counter=STABLE_CYCLES, and either no result exists since reset or freq_in differs from the last classified value.
REQ-013 SHALL, on a trigger edge, capture freq_in into a 16-bit work register, set octave accumulator to 4, and record it as the last classified value.
REQ-014 SHALL use states IDLE, NORM, SEARCH, DONE.
REQ-015 SHALL go IDLE->DONE directly if the captured value is <16 or >8000 (including 0); otherwise IDLE->NORM.
REQ-016 NORM, one action per cycle: work<254 -> shift left 1, octave-1; work>=509 -> shift right 1, octave+1; otherwise -> SEARCH with no shift. NORM with k shifts lasts k+1 cycles; k<=5.
REQ-017 SHALL use fixed table, Hz: 262, 277, 294, 311, 330, 349, 370, 392, 415, 440, 466, 494 (idx 0..11).
REQ-018 SEARCH SHALL evaluate one entry per cycle, idx 0..11, for 12 cycles, keeping the minimum |work-table|.
REQ-019 A tie SHALL keep the lower index (strict less-than replacement).
REQ-020 DONE SHALL last one cycle, register outputs, pulse note_valid, then return to IDLE.
REQ-021 In-range latency: note_valid SHALL be high exactly k+14 cycles after the capture edge.
REQ-022 Out-of-range: note_valid SHALL be high 1 cycle after the capture edge, with note_idx=0, octave=0, freq_err=0 and out_of_range=1.
REQ-023 In-range DONE SHALL clear out_of_range.
REQ-024 Outputs other than note_valid and busy SHALL hold between DONE cycles.
REQ-025 freq_in changes during NORM/SEARCH/DONE SHALL NOT affect the in-flight result.
REQ-026 The stability counter SHALL keep running in all states.
REQ-027 A stable value equal to the last classified value SHALL NOT retrigger, giving exactly one note_valid per distinct stable value.

Reset
REQ-028 Reset SHALL force state IDLE and counter 0, clear the result-exists flag, and set all outputs to 0.
REQ-029 Reset SHALL take priority over every state, including mid-NORM/SEARCH; the in-flight result is discarded with no note_valid.

Verification
REQ-030 freq_in=440 held -> after 1024 stable cycles, note_valid after 14 more cycles: idx 9, octave 4, err 0, out_of_range 0.
REQ-031 freq_in=110 (k=2) -> idx 9, octave 2, err 0, latency 16; freq_in=16 (k=4) -> idx 0, octave 0, err -6.
REQ-032 freq_in=8000 (k=4, work 500) -> idx 11, octave 8, err +6; freq_in=381 -> tie F#/G -> idx 6, err +11.
REQ-033 freq_in=0 and freq_in=9000 -> out_of_range=1, idx/octave/err 0, note_valid 1 cycle after capture.
REQ-034 freq_in alternating 440/441 every 500 cycles -> no note_valid. 440 held 10000 cycles -> exactly one note_valid.
REQ-035 Reset asserted during SEARCH -> outputs 0, busy 0, no note_valid. Same value still stable after release -> reclassified once.
